// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control FSM: state codes,
// opcodes and datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_ADDR    = 4'd5,
    S_MEM_RD  = 4'd6,
    S_LOAD_WB = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12,
    S_EXC_OVF = 4'd13
  } ctrl_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_SHL2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // A counter must be at least one bit wide even when no wait cycles exist.
  function automatic int waitCntWidth(input int memWait);
    return (memWait < 1) ? 1 : $clog2(memWait + 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts cycles spent in a memory state; done_o marks the final wait cycle
// of a MEM_WAIT+1 cycle access.
module mem_wait_counter
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int CW = waitCntWidth(MEM_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled memory state keeps reporting done.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset datapath.
// Define CTRL_OVF_EXC_EN to trap arithmetic overflow into the EXC_OVF state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int         MEM_WAIT       = 0,
  parameter logic [1:0] EXC_VECTOR_SEL = PCSRC_EXC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       EPCWrite,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  ctrl_state_e state_q, state_d;
  logic        memEn;
  logic        memClr;
  logic        memDone;

  // ALU decode from funct happens outside this block.
  logic unusedFunct;
  assign unusedFunct = ^funct;

`ifndef CTRL_OVF_EXC_EN
  logic       unusedOverflow;
  logic [1:0] unusedExcSel;
  assign unusedOverflow = overflow;
  assign unusedExcSel   = EXC_VECTOR_SEL;
`endif

  assign memEn  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign memClr = (state_d != state_q);

  mem_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .en_i  (memEn),
    .clr_i (memClr),
    .done_o(memDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode from state and wait counter; only illegal_op and the
  // zero-gated PCWrite in BRANCH look at live inputs.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    EPCWrite    = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        if (memDone) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        ALUSrcB = SRCB_SHL2;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end

      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REGB;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALU_WB;
`ifdef CTRL_OVF_EXC_EN
        if (overflow) state_d = S_EXC_OVF;
`endif
      end

      S_ALU_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
        case (opcode)
          OP_LW:   state_d = S_MEM_RD;
          OP_SW:   state_d = S_MEM_WR;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (memDone) state_d = S_LOAD_WB;
      end

      S_LOAD_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (memDone) state_d = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REGB;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCWrite     = zero;
        PCSource    = PCSRC_ALUOUT;
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = S_FETCH;
      end

      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
        state_d = S_ADDI_WB;
`ifdef CTRL_OVF_EXC_EN
        if (overflow) state_d = S_EXC_OVF;
`endif
      end

      S_ADDI_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

`ifdef CTRL_OVF_EXC_EN
      S_EXC_OVF: begin
        EPCWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = EXC_VECTOR_SEL;
        state_d  = S_FETCH;
      end
`endif

      default: state_d = S_FETCH;
    endcase
  end

  assign state_dbg = state_q;

endmodule
